// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes, shared byte-memory port and busy flag for mem_arbiter.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface mem_arbiter_if #(parameter int ADDR_W = 10);
  logic              a_req,   b_req;
  logic              a_we,    b_we;
  logic [ADDR_W-1:0] a_addr,  b_addr;
  logic [31:0]       a_wdata, b_wdata;
  logic              a_ack,   b_ack;
  logic [31:0]       a_rdata, b_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_re,  mem_we;
  logic [7:0]        mem_rdata;
  logic              busy;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
    output a_ack, b_ack, a_rdata, b_rdata, mem_addr, mem_wdata, mem_re, mem_we, busy
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
    input  a_ack, b_ack, a_rdata, b_rdata, mem_addr, mem_wdata, mem_re, mem_we, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving a CPU (A) and a DMA (B) 32-bit word access to a byte-wide
// memory; each access is split into four little-endian byte beats.
module mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input logic        clk,
  input logic        rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, RWAIT, DONE} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state_q, state_d;
  logic [1:0]        beat_q;
  logic              sel_q;       // 0 = A, 1 = B
  logic              last_q;      // requester granted most recently, 1 = B
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [23:0]       rbuf_q;
  logic [31:0]       a_rdata_q, b_rdata_q;
  logic              grant_b;
  logic              xfer;

  // On a tie the requester that did not win last time takes the grant.
  assign grant_b = bus.b_req & (~bus.a_req | ~last_q);
  assign xfer    = (state_q == XFER);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.a_req || bus.b_req) state_d = XFER;
      XFER:    if (beat_q == 2'd3) state_d = we_q ? DONE : RWAIT;
      RWAIT:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 8'h00;
    if (xfer) begin
      bus.mem_re   = ~we_q;
      bus.mem_we   = we_q;
      bus.mem_addr = addr_q + ADDR_W'(beat_q);
      case (beat_q)
        2'd0:    bus.mem_wdata = wdata_q[7:0];
        2'd1:    bus.mem_wdata = wdata_q[15:8];
        2'd2:    bus.mem_wdata = wdata_q[23:16];
        default: bus.mem_wdata = wdata_q[31:24];
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.a_ack   = (state_q == DONE) & ~sel_q;
  assign bus.b_ack   = (state_q == DONE) & sel_q;
  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      rbuf_q    <= 24'h0;
      a_rdata_q <= 32'h0;
      b_rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            sel_q   <= grant_b;
            last_q  <= grant_b;
            we_q    <= grant_b ? bus.b_we : bus.a_we;
            addr_q  <= (grant_b ? bus.b_addr : bus.a_addr) & ALIGN_MASK;
            wdata_q <= grant_b ? bus.b_wdata : bus.a_wdata;
            beat_q  <= 2'd0;
          end
        end
        XFER: begin
          beat_q <= beat_q + 2'd1;
          // Memory returns the byte one cycle after its strobe, so beat k holds byte k-1.
          if (!we_q) begin
            case (beat_q)
              2'd1:    rbuf_q[7:0]   <= bus.mem_rdata;
              2'd2:    rbuf_q[15:8]  <= bus.mem_rdata;
              2'd3:    rbuf_q[23:16] <= bus.mem_rdata;
              default: ;
            endcase
          end
        end
        RWAIT: begin
          if (sel_q) b_rdata_q <= {bus.mem_rdata, rbuf_q};
          else       a_rdata_q <= {bus.mem_rdata, rbuf_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a byte-memory model and a word-level
// reference model of arbitration order, latency and memory contents.
module tb_mem_arbiter;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  mem_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          who;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mem[1024];
  logic [7:0]  ref_mem[1024];
  bit          last_b = 1'b1;
  logic [31:0] exp_a_rd = 32'h0;
  logic [31:0] exp_b_rd = 32'h0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  // Byte-wide memory with one-cycle registered read.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
    bus.mem_rdata <= 8'h00;
    forever begin
      @(posedge clk);
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  function automatic void mon_side(bit who, logic ack, logic [31:0] rd);
    exp_t e;
    logic [31:0] hold;
    hold = who ? exp_b_rd : exp_a_rd;
    if (ack) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", {31'h0, who}, 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("ack_who", {31'h0, who}, {31'h0, e.who});
        chk("ack_cycle", cyc, e.cyc);
        if (e.rd) begin
          chk("rdata", rd, e.data);
          if (who) exp_b_rd = e.data; else exp_a_rd = e.data;
        end else begin
          chk("rdata_on_write", rd, hold);
        end
      end
    end else begin
      chk("rdata_hold", rd, hold);
    end
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_a_rd = 32'h0;
      exp_b_rd = 32'h0;
    end else begin
      if (bus.a_ack && bus.b_ack) chk("dual_ack", 32'h1, 32'h0);
      mon_side(1'b0, bus.a_ack, bus.a_rdata);
      mon_side(1'b1, bus.b_ack, bus.b_rdata);
      if (!bus.busy)
        chk("idle_bus", {12'h0, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 32'h0);
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    last_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scramble: 0 never, 1 always, 2 random -- drop req and alter operands after grant.
  task automatic do_pair(input bit a_en, input bit a_wr, input logic [AW-1:0] a_ad,
                         input logic [31:0] a_wd, input bit b_en, input bit b_wr,
                         input logic [AW-1:0] b_ad, input logic [31:0] b_wd, input int scramble);
    bit order[2];
    int gt[2];
    int n, g, base, t;
    bit who, wr, seen;
    logic [31:0] wd, data;
    if (a_en && b_en) begin
      order[0] = last_b ? 1'b0 : 1'b1;
      order[1] = ~order[0];
      n = 2;
    end else begin
      order[0] = b_en;
      n = 1;
    end
    @(negedge clk);
    bus.a_req = a_en; bus.a_we = a_wr; bus.a_addr = a_ad; bus.a_wdata = a_wd;
    bus.b_req = b_en; bus.b_we = b_wr; bus.b_addr = b_ad; bus.b_wdata = b_wd;
    g = cyc + 1;
    for (int k = 0; k < n; k++) begin
      who  = order[k];
      wr   = who ? b_wr : a_wr;
      wd   = who ? b_wd : a_wd;
      base = int'(who ? b_ad : a_ad) & 32'h3FC;
      gt[k] = g;
      last_b = who;
      if (wr) begin
        for (int j = 0; j < 4; j++) ref_mem[base + j] = wd[8*j +: 8];
        sbq.push_back('{who: who, rd: 1'b0, data: 32'h0, cyc: g + 4});
        g = g + 6;
      end else begin
        data = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
        sbq.push_back('{who: who, rd: 1'b1, data: data, cyc: g + 5});
        g = g + 7;
      end
    end
    for (int k = 0; k < n; k++) begin
      who = order[k];
      while (cyc < gt[k]) @(negedge clk);
      if (scramble == 1 || (scramble == 2 && $urandom_range(0, 1) == 1)) begin
        if (who) begin
          bus.b_req = 1'b0; bus.b_we = $urandom_range(0, 1);
          bus.b_addr = AW'($urandom); bus.b_wdata = $urandom;
        end else begin
          bus.a_req = 1'b0; bus.a_we = $urandom_range(0, 1);
          bus.a_addr = AW'($urandom); bus.a_wdata = $urandom;
        end
      end
      t = 0;
      seen = who ? bus.b_ack : bus.a_ack;
      while (!seen && t < 12) begin
        @(negedge clk);
        t++;
        seen = who ? bus.b_ack : bus.a_ack;
      end
      chk("ack_timeout", {31'h0, seen}, 32'h1);
      if (who) bus.b_req = 1'b0; else bus.a_req = 1'b0;
    end
  endtask

  initial begin
    int g, a_en, b_en;
    logic [31:0] w;
    bus.a_req = 1'b0; bus.b_req = 1'b0; bus.a_we = 1'b0; bus.b_we = 1'b0;
    bus.a_addr = '0; bus.b_addr = '0; bus.a_wdata = 32'h0; bus.b_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = i[7:0];

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_acks", {30'h0, bus.a_ack, bus.b_ack}, 32'h0);
    chk("rst_strobes", {30'h0, bus.mem_re, bus.mem_we}, 32'h0);
    chk("rst_mem_addr", {22'h0, bus.mem_addr}, 32'h0);
    chk("rst_mem_wdata", {24'h0, bus.mem_wdata}, 32'h0);
    chk("rst_a_rdata", bus.a_rdata, 32'h0);
    chk("rst_b_rdata", bus.b_rdata, 32'h0);
    rst_n = 1'b1;

    do_pair(1, 1, 10'h010, 32'hDEADBEEF, 0, 0, 10'h0, 32'h0, 0);
    chk("wr_bytes", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'hDEADBEEF);
    do_pair(1, 0, 10'h010, 32'h0, 0, 0, 10'h0, 32'h0, 0);

    apply_reset();
    do_pair(1, 1, 10'h080, 32'h11111111, 1, 1, 10'h084, 32'h22222222, 0);
    do_pair(1, 0, 10'h084, 32'h0, 1, 0, 10'h080, 32'h0, 0);

    do_pair(0, 0, 10'h0, 32'h0, 1, 0, 10'h3FE, 32'h0, 0);

    do_pair(1, 1, 10'h100, 32'hCAFEF00D, 0, 0, 10'h0, 32'h0, 1);
    chk("scramble_bytes", {mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]}, 32'hCAFEF00D);

    // Abort a write in beat 2 with an asynchronous reset.
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 10'h020; bus.a_wdata = 32'h44332211;
    g = cyc + 1;
    while (cyc < g + 2) @(negedge clk);
    chk("beat2_busy", {31'h0, bus.busy}, 32'h1);
    #1 rst_n = 1'b0;
    bus.a_req = 1'b0;
    #1;
    chk("abort_mem_we", {31'h0, bus.mem_we}, 32'h0);
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    #1 rst_n = 1'b1;
    last_b = 1'b1;
    ref_mem[32'h20] = 8'h11;
    ref_mem[32'h21] = 8'h22;
    repeat (3) @(negedge clk);
    chk("abort_bytes", {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]}, 32'h23222211);
    do_pair(0, 0, 10'h0, 32'h0, 1, 0, 10'h020, 32'h0, 0);

    for (int it = 0; it < 40; it++) begin
      a_en = $urandom_range(0, 1);
      b_en = a_en ? $urandom_range(0, 1) : 1;
      w = $urandom;
      do_pair(a_en[0], $urandom_range(0, 1), AW'(10'h040 + $urandom_range(0, 31)), w,
              b_en[0], $urandom_range(0, 1), AW'($urandom_range(0, 3) == 0 ? $urandom : 10'h040 + $urandom_range(0, 31)),
              ~w, 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'h0);
    begin
      int first_bad;
      first_bad = -1;
      for (int i = 0; i < 1024; i++)
        if (first_bad < 0 && mem[i] !== ref_mem[i]) first_bad = i;
      chk("mem_image_first_bad_addr", first_bad, 32'hFFFF_FFFF);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
